// File: rtl/ahb_dmem_slave.sv
// AHB-Lite data-memory slave: word-organised SRAM with programmable wait
// states and a two-cycle ERROR response for out-of-range, misaligned or
// illegally sized accesses.
module ahb_dmem_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + (33'(DEPTH_WORDS) * 33'd4);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    off_q, off_d;
  logic          wr_q, wr_d;
  logic [1:0]    size_q, size_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          ready_c;
  logic          accept_c;
  logic          err_c;
  logic          cmpl_c;
  logic [3:0]    be_c;
  logic          unused_htrans;

  // Only NONSEQ/SEQ matter; BUSY and IDLE are treated alike.
  assign unused_htrans = HTRANS[0];

  // Slave stalls only while counting wait states or in the first error cycle.
  assign ready_c  = (state_q != S_WAIT) && (state_q != S_ERR1);
  assign accept_c = HSEL && HREADY && HTRANS[1] && ready_c;
  // Pending OKAY transfer whose data phase closes this cycle.
  assign cmpl_c   = (state_q == S_IDLE) && pend_q;

  // Address-phase legality check.
  always_comb begin
    err_c = 1'b0;
    if (({1'b0, HADDR} < 33'(BASE_ADDR)) || ({1'b0, HADDR} >= END_ADDR)) err_c = 1'b1;
    if (HSIZE > 3'b010) err_c = 1'b1;
    if ((HSIZE == 3'b001) && HADDR[0]) err_c = 1'b1;
    if ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00)) err_c = 1'b1;
  end

  // Byte-lane enables for the registered write.
  always_comb begin
    be_c = 4'b1111;
    case (size_q)
      2'b00:   be_c = 4'b0001 << off_q;
      2'b01:   be_c = off_q[1] ? 4'b1100 : 4'b0011;
      default: be_c = 4'b1111;
    endcase
  end

  // Next-state logic: data-phase sequencing and address-phase capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    off_d   = off_q;
    wr_d    = wr_q;
    size_d  = size_q;
    case (state_q)
      S_IDLE, S_ERR2: begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_ERR1: state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (accept_c) begin
      idx_d  = HADDR[AW+1:2];
      off_d  = HADDR[1:0];
      wr_d   = HWRITE;
      size_d = HSIZE[1:0];
      if (err_c) begin
        state_d = S_ERR1;
        pend_d  = 1'b0;
      end else if (WAIT_STATES > 0) begin
        state_d = S_WAIT;
        cnt_d   = 3'(WAIT_STATES - 1);
        pend_d  = 1'b1;
      end else begin
        state_d = S_IDLE;
        pend_d  = 1'b1;
      end
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      pend_q  <= 1'b0;
      idx_q   <= '0;
      off_q   <= 2'b00;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
    end
  end

  // Array write at the closing edge of an OKAY write data phase.
  always_ff @(posedge clk) begin
    if (!rst && cmpl_c && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  // Response outputs decoded from the registered state.
  assign HREADYOUT = ready_c;
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign HRDATA    = (cmpl_c && !wr_q) ? mem[idx_q] : 32'h0;

endmodule

// File: tb/tb_ahb_dmem_slave.sv
// Bench for ahb_dmem_slave: three instances (0, 2 and 3 wait states), one
// selected at a time, driven by a pipelined AHB master and checked cycle by
// cycle against a scoreboard of expected data phases.
module tb_ahb_dmem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel_v;
  int          cur;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;

  logic        hsel   [3];
  logic        hro    [3];
  logic        hresp  [3];
  logic [31:0] hrdata [3];

  logic        hro_m;
  logic        hresp_m;
  logic [31:0] hrd_m;

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          ws_tab [3] = '{0, 2, 3};
  bit          model_en = 1'b1;
  logic [31:0] mdl [3][1024];
  int          ph = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 3; k++) hsel[k] = hsel_v && (cur == k);
    hro_m   = hro[cur];
    hresp_m = hresp[cur];
    hrd_m   = hrdata[cur];
  end

  ahb_dmem_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hro[0]),
    .HREADYOUT(hro[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

  ahb_dmem_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hro[1]),
    .HREADYOUT(hro[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

  ahb_dmem_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hro[2]),
    .HREADYOUT(hro[2]), .HRESP(hresp[2]), .HRDATA(hrdata[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One address phase; returns just after the accepting edge with HWDATA driven.
  task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [1:0] tr, input logic sel);
    int          n;
    exp_t        e;
    logic [9:0]  idx;
    bit          en;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    htrans = tr;
    hsel_v = sel;
    n = 0;
    while (!hro_m && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("issue_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    hwdata = wd;
    htrans = 2'b00;
    hsel_v = 1'b0;
    if (sel && tr[1]) begin
      e.err = (a >= 32'h1000) || (sz > 3'd2) || (sz == 3'd1 && a[0]) ||
              (sz == 3'd2 && a[1:0] != 2'b00);
      e.rd   = !w;
      e.data = 32'h0;
      idx    = a[11:2];
      if (!e.err) begin
        if (w && model_en) begin
          for (int b = 0; b < 4; b++) begin
            en = (sz == 3'd2) || (sz == 3'd1 && (b / 2) == int'(a[1])) ||
                 (sz == 3'd0 && b == int'(a[1:0]));
            if (en) mdl[cur][idx][8*b +: 8] = wd[8*b +: 8];
          end
        end
        e.data = mdl[cur][idx];
      end
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    htrans = 2'b00;
    hsel_v = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Per-cycle response check against the oldest outstanding data phase.
  always @(negedge clk) begin
    exp_t        e;
    bit          last;
    logic [31:0] exp_rd;
    if (!rst) begin
      if (sb.size() == 0) begin
        ph = 0;
        chk("idle_ready", 32'(hro_m), 32'd1);
        chk("idle_resp", 32'(hresp_m), 32'd0);
        chk("idle_rdata", hrd_m, 32'h0);
      end else begin
        ph++;
        e      = sb[0];
        last   = e.err ? (ph == 2) : (ph == ws_tab[cur] + 1);
        exp_rd = (!e.err && e.rd && last) ? e.data : 32'h0;
        chk("dp_ready", 32'(hro_m), 32'(last));
        chk("dp_resp", 32'(hresp_m), 32'(e.err));
        chk("dp_rdata", hrd_m, exp_rd);
        if (last || ph > 8) begin
          if (!last) chk("dp_timeout", 32'd0, 32'd1);
          void'(sb.pop_front());
          ph = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; hsel_v = 1'b0; htrans = 2'b00; haddr = 32'h0;
    hwrite = 1'b0; hsize = 3'd2; hwdata = 32'h0; cur = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", 32'(hro[k]), 32'd1);
      chk("rst_resp", 32'(hresp[k]), 32'd0);
      chk("rst_rdata", hrdata[k], 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero wait states: back-to-back write then read.
    cur = 0;
    issue(32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF, 2'b10, 1'b1);
    issue(32'h10, 1'b0, 3'd2, 32'h0, 2'b10, 1'b1);
    idle(2);

    // Sub-word writes with junk on the unused lanes.
    issue(32'h0, 1'b1, 3'd2, 32'h0, 2'b10, 1'b1);
    issue(32'h1, 1'b1, 3'd0, 32'h1122_AA33, 2'b10, 1'b1);
    issue(32'h2, 1'b1, 3'd1, 32'hBBCC_4455, 2'b10, 1'b1);
    issue(32'h0, 1'b0, 3'd2, 32'h0, 2'b10, 1'b1);
    idle(2);

    // Error responses, including back-to-back errors, then readback.
    issue(32'h3, 1'b1, 3'd2, 32'hFFFF_FFFF, 2'b10, 1'b1);
    issue(32'h1000, 1'b1, 3'd2, 32'hFFFF_FFFF, 2'b10, 1'b1);
    issue(32'h0, 1'b1, 3'b011, 32'hFFFF_FFFF, 2'b10, 1'b1);
    issue(32'h1, 1'b1, 3'd1, 32'hFFFF_FFFF, 2'b11, 1'b1);
    issue(32'h1000, 1'b0, 3'd2, 32'h0, 2'b10, 1'b1);
    issue(32'h0, 1'b0, 3'd2, 32'h0, 2'b10, 1'b1);
    idle(2);

    // IDLE/BUSY selected and NONSEQ unselected must not touch the array.
    issue(32'h0, 1'b1, 3'd2, 32'hFFFF_FFFF, 2'b00, 1'b1);
    issue(32'h0, 1'b1, 3'd2, 32'hFFFF_FFFF, 2'b01, 1'b1);
    issue(32'h0, 1'b1, 3'd2, 32'hFFFF_FFFF, 2'b10, 1'b0);
    issue(32'h0, 1'b0, 3'd2, 32'h0, 2'b10, 1'b1);
    idle(2);

    // Two wait states.
    cur = 1;
    issue(32'h20, 1'b1, 3'd2, 32'h1234_5678, 2'b10, 1'b1);
    idle(1);
    issue(32'h20, 1'b0, 3'd2, 32'h0, 2'b10, 1'b1);
    issue(32'h24, 1'b1, 3'd2, 32'hCAFE_F00D, 2'b10, 1'b1);
    issue(32'h24, 1'b0, 3'd2, 32'h0, 2'b10, 1'b1);
    issue(32'h7, 1'b0, 3'd2, 32'h0, 2'b10, 1'b1);
    issue(32'h20, 1'b0, 3'd2, 32'h0, 2'b11, 1'b1);
    idle(3);

    // Three wait states: reset in the second wait cycle drops the write.
    cur = 2;
    issue(32'h40, 1'b1, 3'd2, 32'h1111_1111, 2'b10, 1'b1);
    idle(1);
    model_en = 1'b0;
    issue(32'h40, 1'b1, 3'd2, 32'h2222_2222, 2'b10, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    model_en = 1'b1;
    issue(32'h40, 1'b0, 3'd2, 32'h0, 2'b10, 1'b1);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
